// File: rtl/seg7_scroll_ctrl.sv
// seg7_scroll_ctrl
//
// Scrolls a message held in a small buffer across a bank of four 9-bit
// seven-segment display registers. Software loads the message through the
// msg_* port, then pulses start. Each scroll step rewrites all four display
// registers in a 4-cycle burst, leftmost digit first. The burst is followed
// by TICK_DIV idle cycles, and then the window moves on.
//
// Build option: SEG7_SCROLL_BOUNCE_EN
//   undefined : the window start wraps continuously, head = (head + 1) mod len
//   defined   : the window start ping-pongs between 0 and len-4. It holds for
//               one step at each end while it turns around. It stays at 0
//               when len <= 4.
//
// Parameters
//   MSG_DEPTH  message buffer entries (power of two, >= 4)
//   TICK_DIV   idle cycles between scroll steps (>= 1)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   msg_wr     write msg_data into buffer[msg_addr] this cycle
//   msg_addr   buffer write address
//   msg_data   9-bit display code to store
//   msg_len    active message length, sampled when start is accepted
//   start      begin scrolling (pulse, ignored while running)
//   stop       halt scrolling (pulse, an in-flight burst always completes)
//   seg_sel    one-hot display register select, bit 3 = leftmost digit
//   seg_value  value written to the selected display register
//   seg_write  write strobe to the display bank
//   running    high while a scroll is active (burst or wait)
//   step_done  one-cycle pulse on the last write of each frame
module seg7_scroll_ctrl #(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 12500000,
    localparam int AW = $clog2(MSG_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          msg_wr,
    input  logic [AW-1:0] msg_addr,
    input  logic [8:0]    msg_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          stop,
    output logic [3:0]    seg_sel,
    output logic [8:0]    seg_value,
    output logic          seg_write,
    output logic          running,
    output logic          step_done
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REFRESH = 2'd1,
        S_WAIT    = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      k_reg, k_next;
    logic [AW-1:0]   head_reg, head_next, head_adv;
    logic [AW:0]     len_reg, len_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            stop_pend_reg, stop_pend_next;
`ifdef SEG7_SCROLL_BOUNCE_EN
    logic            dir_reg, dir_next, dir_adv;   // 1 = forward
`endif

    logic [8:0]      mem_reg [MSG_DEPTH];
    logic [AW-1:0]   rd_idx;

    logic [3:0]      seg_sel_reg;
    logic [8:0]      seg_value_reg;
    logic            seg_write_reg;
    logic            running_reg;
    logic            step_done_reg;

    // (base + ofs) mod n for base < n and ofs <= 3. The sum can reach at
    // most n + 2, and with n = 1 it can exceed n by three multiples, so
    // three conditional subtractions always reduce it fully.
    function automatic logic [AW-1:0] wrap_index(
        input logic [AW-1:0] base,
        input logic [1:0]    ofs,
        input logic [AW:0]   n
    );
        logic [AW+1:0] s;
        s = {2'b00, base} + {{AW{1'b0}}, ofs};
        for (int i = 0; i < 3; i++) begin
            if (s >= {1'b0, n}) begin
                s = s - {1'b0, n};
            end
        end
        return s[AW-1:0];
    endfunction

    // Where the window starts on the next scroll step.
`ifdef SEG7_SCROLL_BOUNCE_EN
    always_comb begin
        head_adv = head_reg;
        dir_adv  = dir_reg;
        if (len_reg <= (AW+1)'(4)) begin
            head_adv = '0;
        end else if (dir_reg) begin
            // At the far end, turn around and hold for one step.
            if ({1'b0, head_reg} == len_reg - (AW+1)'(4)) begin
                dir_adv = 1'b0;
            end else begin
                head_adv = head_reg + 1'b1;
            end
        end else begin
            if (head_reg == '0) begin
                dir_adv = 1'b1;
            end else begin
                head_adv = head_reg - 1'b1;
            end
        end
    end
`else
    logic [AW:0] head_inc;
    always_comb begin
        head_inc = {1'b0, head_reg} + 1'b1;
        head_adv = (head_inc >= len_reg) ? '0 : head_inc[AW-1:0];
    end
`endif

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        head_next      = head_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        stop_pend_next = stop_pend_reg;
`ifdef SEG7_SCROLL_BOUNCE_EN
        dir_next       = dir_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // Stop in the same cycle wins over start.
                if (start && !stop && (msg_len != '0)) begin
                    state_next     = S_REFRESH;
                    k_next         = 2'd0;
                    head_next      = '0;
                    len_next       = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
                    stop_pend_next = 1'b0;
`ifdef SEG7_SCROLL_BOUNCE_EN
                    dir_next       = 1'b1;
`endif
                end
            end
            S_REFRESH: begin
                if (k_reg == 2'd3) begin
                    if (stop_pend_reg || stop) begin
                        state_next     = S_IDLE;
                        stop_pend_next = 1'b0;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = '0;
                    end
                end else begin
                    // A stop mid-burst is remembered so the frame is never cut short.
                    k_next = k_reg + 2'd1;
                    if (stop) begin
                        stop_pend_next = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_next     = S_IDLE;
                    stop_pend_next = 1'b0;
                end else if (cnt_reg == CW'(TICK_DIV - 1)) begin
                    state_next = S_REFRESH;
                    k_next     = 2'd0;
                    head_next  = head_adv;
`ifdef SEG7_SCROLL_BOUNCE_EN
                    dir_next   = dir_adv;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The outputs are registered from the next state, so the first write
    // appears in the cycle right after start is accepted. The buffer read
    // is registered. A write to the same entry at the same edge therefore
    // leaves the old value on the display.
    assign rd_idx = wrap_index(head_next, k_next, len_next);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            k_reg         <= 2'd0;
            head_reg      <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            stop_pend_reg <= 1'b0;
`ifdef SEG7_SCROLL_BOUNCE_EN
            dir_reg       <= 1'b1;
`endif
            seg_sel_reg   <= '0;
            seg_value_reg <= '0;
            seg_write_reg <= 1'b0;
            running_reg   <= 1'b0;
            step_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            head_reg      <= head_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            stop_pend_reg <= stop_pend_next;
`ifdef SEG7_SCROLL_BOUNCE_EN
            dir_reg       <= dir_next;
`endif
            seg_write_reg <= (state_next == S_REFRESH);
            seg_sel_reg   <= (state_next == S_REFRESH) ? (4'b1000 >> k_next) : 4'b0000;
            seg_value_reg <= (state_next == S_REFRESH) ? mem_reg[rd_idx] : 9'd0;
            step_done_reg <= (state_next == S_REFRESH) && (k_next == 2'd3);
            running_reg   <= (state_next != S_IDLE);
        end
    end

    // The message buffer is cleared by reset, so a restart never shows stale text.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                mem_reg[i] <= 9'd0;
            end
        end else if (msg_wr) begin
            mem_reg[msg_addr] <= msg_data;
        end
    end

    assign seg_sel   = seg_sel_reg;
    assign seg_value = seg_value_reg;
    assign seg_write = seg_write_reg;
    assign running   = running_reg;
    assign step_done = step_done_reg;

endmodule

// File: doc/seg7_scroll_ctrl.md
# seg7_scroll_ctrl

Sequencer that scrolls a message across the four 9-bit seven-segment display registers. It holds a small message buffer loaded by the processor, and on each scroll step it rewrites all four display registers in a 4-cycle burst using one-hot segment select, write strobe and 9-bit value. It sits between the processor's I/O write path and the four-register display bank, so software loads the text once and issues start instead of hand-writing each frame.

## Interface
- MSG_DEPTH, 16: message buffer entries; power of two, ≥4; AW = log2(MSG_DEPTH)
- TICK_DIV, 12500000: WAIT-state clock cycles between scroll steps; ≥1
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- msg_wr  in  1  write msg_data into buffer[msg_addr] this cycle
- msg_addr  in  AW  buffer write address
- msg_data  in  9  display code to store
- msg_len  in  AW+1  active message length, sampled on accepted start
- start  in  1  begin scrolling (pulse)
- stop  in  1  halt scrolling (pulse)
- seg_sel  out  4  one-hot display register select; bit3 = leftmost digit
- seg_value  out  9  value driven to selected register
- seg_write  out  1  write strobe to display bank
- running  out  1  high in REFRESH or WAIT
- step_done  out  1  one-cycle pulse on last write of each frame

## Operation
- Registers: buffer[MSG_DEPTH] of 9 bits, len (AW+1), head (AW), k (2-bit burst index), tick counter, stop_pend flag.
- States: IDLE, REFRESH, WAIT.
- IDLE: start with msg_len ≠ 0 → len = min(msg_len, MSG_DEPTH), head = 0, k = 0 → REFRESH. start with msg_len = 0 is ignored.
- REFRESH, cycle k (0..3): seg_write = 1, seg_sel = 1 << (3−k), seg_value = buffer[(head+k) mod len]. k = 3 asserts step_done. After k = 3: stop_pend → IDLE, else → WAIT with counter = 0.
- WAIT: counter increments. When counter = TICK_DIV−1, head advances (see Configuration) → REFRESH, k = 0.
- len < 4: indices wrap mod len, so characters repeat across digits (len = 1 shows the same character on all four).
- stop in WAIT → IDLE next cycle. stop in REFRESH sets stop_pend; the burst completes (no partial frame), then IDLE. stop_pend clears on entering IDLE.
- start while running is ignored. start and stop in the same cycle: stop wins (start ignored in IDLE).
- Display registers keep their last frame after stop; the block never clears them.
- msg_wr is accepted in every state. A read and write of the same entry in the same cycle returns the old value. New data appears on the next frame that reads that entry.
- Outside REFRESH: seg_write = 0, seg_sel = 0, seg_value = 0.
- All outputs are registered.

## Timing
- Reset: state = IDLE; seg_sel = 0, seg_value = 0, seg_write = 0, running = 0, step_done = 0; buffer, head, len, counter and stop_pend cleared.
- Reset mid-burst aborts immediately. No further writes occur.
- start sampled at edge t → seg_write high on cycles t+1..t+4 with seg_sel 1000, 0100, 0010, 0001; step_done at t+4; running high from t+1.
- Step period = TICK_DIV + 4 cycles. The next burst starts at t+5+TICK_DIV.
- stop sampled in WAIT at t → running = 0 at t+1.

## Configuration
- SEG7_SCROLL_BOUNCE_EN defined: head ping-pongs. It increments until head = len−4, then decrements to 0, then increments again. The direction flag resets to forward on reset and on start. If len ≤ 4, head stays 0.
- Undefined: head = (head+1) mod len (continuous wrap).

## Test plan
- Reset then idle, TICK_DIV = 3: all outputs 0, no seg_write for 20 cycles.
- Load buffer[0..5] = 0x01..0x06, msg_len = 6, start → frame 1 writes seg3..seg0 = 01, 02, 03, 04. After 3 WAIT cycles, frame 2 = 02, 03, 04, 05. Frame 5 = 05, 06, 01, 02 (wrap). With BOUNCE_EN, frame 4 = 03, 04, 05, 06 (head = 2), frame 5 = 02, 03, 04, 05 (reversed).
- msg_len = 2 (buffer 0x0A, 0x0B) → frame 1 = 0A, 0B, 0A, 0B, frame 2 = 0B, 0A, 0B, 0A. msg_len = 0 start → remains IDLE.
- stop asserted on the second write of a burst → remaining two writes still occur, step_done pulses, running = 0 the next cycle. stop in WAIT → IDLE in 1 cycle. start + stop together in IDLE → stays IDLE.
- msg_wr to buffer[2] = 0x1FF during frame 1's k = 2 read → frame 1 shows the old value. The next frame that reads index 2 shows 0x1FF.
- Reset asserted on the third burst cycle → seg_write = 0 next cycle, all state cleared. A following start restarts from head = 0.
